// File: rtl/qrisc_avalon_arbiter_pkg.sv
// qrisc_avalon_arbiter_pkg
//   Shared types and constants for the qrisc32 Avalon bus arbiter.
//   arb_state_t     : arbiter FSM encoding (idle / grant held)
//   ARB_MAX_MASTERS : upper bound on the number of master ports
package qrisc_avalon_arbiter_pkg;

    localparam int unsigned ARB_MAX_MASTERS = 8;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/qrisc_avalon_arbiter_if.sv
// qrisc_avalon_arbiter_if
//   Bundle of the N-master side and the shared slave side of the arbiter.
//   m_addr/m_wdata/m_rd/m_wr : per-master request (packed per master)
//   m_wait_req               : per-master wait request
//   m_rdata                  : read data broadcast to all masters
//   s_addr/s_wdata/s_rd/s_wr : shared slave request
//   s_wait_req/s_rdata       : shared slave response
//   grant_idx                : current grant index (debug/trace)
//   Modport master : the arbiter, which masters the shared slave bus.
//   Modport slave  : the environment (CPU masters plus the slave device).
interface qrisc_avalon_arbiter_if #(
    parameter int unsigned N_MASTERS = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
);
    localparam int unsigned IDX_W = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0][ADDR_W-1:0] m_addr;
    logic [N_MASTERS-1:0][DATA_W-1:0] m_wdata;
    logic [N_MASTERS-1:0]             m_rd;
    logic [N_MASTERS-1:0]             m_wr;
    logic [N_MASTERS-1:0]             m_wait_req;
    logic [DATA_W-1:0]                m_rdata;
    logic [ADDR_W-1:0]                s_addr;
    logic [DATA_W-1:0]                s_wdata;
    logic                             s_rd;
    logic                             s_wr;
    logic                             s_wait_req;
    logic [DATA_W-1:0]                s_rdata;
    logic [IDX_W-1:0]                 grant_idx;

    modport master (
        input  m_addr, m_wdata, m_rd, m_wr, s_wait_req, s_rdata,
        output m_wait_req, m_rdata, s_addr, s_wdata, s_rd, s_wr, grant_idx
    );

    modport slave (
        output m_addr, m_wdata, m_rd, m_wr, s_wait_req, s_rdata,
        input  m_wait_req, m_rdata, s_addr, s_wdata, s_rd, s_wr, grant_idx
    );

endinterface

// File: rtl/qrisc_avalon_arbiter_pick.sv
// qrisc_arb_pick
//   Combinational winner picker.
//   req   : request vector
//   mask  : requests excluded from this pick
//   ptr   : round-robin pointer (last winner)
//   valid : a winner exists
//   idx   : winner index
//   Macro QRISC_ARB_ROUND_ROBIN_EN: defined -> round-robin starting at ptr+1
//   with ptr checked last; undefined -> fixed priority, lowest index wins.
module qrisc_arb_pick #(
    parameter int unsigned N_MASTERS = 3
) (
    input  logic [N_MASTERS-1:0]         req,
    input  logic [N_MASTERS-1:0]         mask,
    input  logic [$clog2(N_MASTERS)-1:0] ptr,
    output logic                         valid,
    output logic [$clog2(N_MASTERS)-1:0] idx
);
    localparam int unsigned IDX_W = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] elig;
    assign elig = req & ~mask;

`ifdef QRISC_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // k = N_MASTERS lands back on ptr, so the last winner is checked last.
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N_MASTERS);
            if (elig[cand] && !valid) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (elig[i] && !valid) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/qrisc_avalon_arbiter.sv
// qrisc_avalon_arbiter
//   N-master to one-slave Avalon arbiter for qrisc32. Registered grant held
//   for the whole wait-request-stretched transfer; back-to-back transfers
//   from different masters run without an idle cycle.
//   clk    : clock, rising edge
//   areset : asynchronous active-low reset
//   bus    : master/slave bundle (qrisc_avalon_arbiter_if.master)
//   Macro QRISC_ARB_ROUND_ROBIN_EN selects round-robin (defined) or fixed
//   lowest-index priority (undefined, no pointer register).
module qrisc_avalon_arbiter #(
    parameter int unsigned N_MASTERS = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                    clk,
    input  logic                    areset,
    qrisc_avalon_arbiter_if.master  bus
);
    import qrisc_avalon_arbiter_pkg::*;

    localparam int unsigned IDX_W = $clog2(N_MASTERS);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] pick_mask;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     pick_ptr;
    logic                 grant_load;

    assign req = bus.m_rd | bus.m_wr;

    // While granted, the holder's request is the transfer in flight, so it
    // is excluded from the pick made in its completion cycle.
    always_comb begin
        pick_mask = '0;
        if (state_q == ARB_GRANT) begin
            pick_mask[grant_q] = 1'b1;
        end
    end

    qrisc_arb_pick #(
        .N_MASTERS(N_MASTERS)
    ) u_pick (
        .req  (req),
        .mask (pick_mask),
        .ptr  (pick_ptr),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

`ifdef QRISC_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_load) begin
            ptr_d = pick_idx;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            ptr_q <= IDX_W'(N_MASTERS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = '0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_load = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d    = ARB_GRANT;
                    grant_load = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (!req[grant_q]) begin
                    // Request withdrawn before completion: abandon.
                    state_d = ARB_IDLE;
                end else if (!bus.s_wait_req) begin
                    if (pick_valid) begin
                        grant_load = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (grant_load) begin
            grant_d = pick_idx;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Slave side is a combinational mux of the granted master; rd is
    // suppressed when the same master also asserts wr.
    always_comb begin
        bus.s_addr     = '0;
        bus.s_wdata    = '0;
        bus.s_rd       = 1'b0;
        bus.s_wr       = 1'b0;
        bus.m_wait_req = '1;
        if (state_q == ARB_GRANT) begin
            bus.s_addr              = bus.m_addr[grant_q];
            bus.s_wdata             = bus.m_wdata[grant_q];
            bus.s_wr                = bus.m_wr[grant_q];
            bus.s_rd                = bus.m_rd[grant_q] & ~bus.m_wr[grant_q];
            bus.m_wait_req[grant_q] = bus.s_wait_req;
        end
    end

    assign bus.m_rdata   = bus.s_rdata;
    assign bus.grant_idx = grant_q;

endmodule

// File: tb/tb_qrisc_avalon_arbiter.sv
module tb_qrisc_avalon_arbiter;

    logic clk;
    logic areset;
    int   n_checks;
    int   n_errors;

    qrisc_avalon_arbiter_if #(
        .N_MASTERS(3),
        .ADDR_W   (32),
        .DATA_W   (32)
    ) bus ();

    qrisc_avalon_arbiter #(
        .N_MASTERS(3),
        .ADDR_W   (32),
        .DATA_W   (32)
    ) dut (
        .clk   (clk),
        .areset(areset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_masters();
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_rd    = '0;
        bus.m_wr    = '0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_wait"}, 64'(bus.m_wait_req), 64'h7);
        check({tag, "_s_rd"}, 64'(bus.s_rd), 64'h0);
        check({tag, "_s_addr"}, 64'(bus.s_addr), 64'h0);
    endtask

    logic [1:0] rr_exp [6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        areset   = 1'b0;
        clear_masters();
        bus.s_wait_req = 1'b0;
        bus.s_rdata    = '0;

        // Reset values
        repeat (2) @(posedge clk);
        sample();
        check("rst_s_rd", 64'(bus.s_rd), 64'h0);
        check("rst_s_wr", 64'(bus.s_wr), 64'h0);
        check("rst_s_addr", 64'(bus.s_addr), 64'h0);
        check("rst_s_wdata", 64'(bus.s_wdata), 64'h0);
        check("rst_wait", 64'(bus.m_wait_req), 64'h7);
        check("rst_grant", 64'(bus.grant_idx), 64'h0);
        tick();
        areset = 1'b1;

        // Single read from master 1, zero-wait slave
        tick();
        bus.m_rd[1]    = 1'b1;
        bus.m_addr[1]  = 32'h100;
        bus.s_wait_req = 1'b0;
        bus.s_rdata    = 32'hCAFEF00D;
        sample();
        check_idle("rd_c0");
        tick();
        sample();
        check("rd_c1_s_rd", 64'(bus.s_rd), 64'h1);
        check("rd_c1_s_addr", 64'(bus.s_addr), 64'h100);
        check("rd_c1_wait", 64'(bus.m_wait_req), 64'h5);
        check("rd_c1_grant", 64'(bus.grant_idx), 64'h1);
        check("rd_c1_rdata", 64'(bus.m_rdata), 64'hCAFEF00D);
        tick();
        bus.m_rd[1] = 1'b0;
        sample();
        check_idle("rd_c2");

        // Wait stretch: master 2 writes, slave stalls 3 cycles, master 0 waits
        tick();
        bus.m_wr[2]    = 1'b1;
        bus.m_addr[2]  = 32'h40;
        bus.m_wdata[2] = 32'h55;
        bus.s_wait_req = 1'b1;
        sample();
        tick();
        bus.m_rd[0]   = 1'b1;
        bus.m_addr[0] = 32'h200;
        sample();
        check("ws_c1_grant", 64'(bus.grant_idx), 64'h2);
        check("ws_c1_s_wr", 64'(bus.s_wr), 64'h1);
        check("ws_c1_s_rd", 64'(bus.s_rd), 64'h0);
        check("ws_c1_s_addr", 64'(bus.s_addr), 64'h40);
        check("ws_c1_s_wdata", 64'(bus.s_wdata), 64'h55);
        check("ws_c1_wait", 64'(bus.m_wait_req), 64'h7);
        for (int i = 0; i < 2; i++) begin
            tick();
            sample();
            check("ws_hold_grant", 64'(bus.grant_idx), 64'h2);
            check("ws_hold_wait", 64'(bus.m_wait_req), 64'h7);
        end
        tick();
        bus.s_wait_req = 1'b0;
        sample();
        check("ws_c4_grant", 64'(bus.grant_idx), 64'h2);
        check("ws_c4_wait", 64'(bus.m_wait_req), 64'h3);
        tick();
        bus.m_wr[2] = 1'b0;
        sample();
        check("ws_c5_grant", 64'(bus.grant_idx), 64'h0);
        check("ws_c5_s_rd", 64'(bus.s_rd), 64'h1);
        check("ws_c5_s_addr", 64'(bus.s_addr), 64'h200);
        check("ws_c5_wait", 64'(bus.m_wait_req), 64'h6);
        tick();
        bus.m_rd[0] = 1'b0;
        sample();
        check_idle("ws_c6");

        // rd and wr together on master 0
        tick();
        bus.m_rd[0]    = 1'b1;
        bus.m_wr[0]    = 1'b1;
        bus.m_addr[0]  = 32'h80;
        bus.m_wdata[0] = 32'h1234;
        sample();
        tick();
        sample();
        check("rw_s_wr", 64'(bus.s_wr), 64'h1);
        check("rw_s_rd", 64'(bus.s_rd), 64'h0);
        check("rw_s_addr", 64'(bus.s_addr), 64'h80);
        check("rw_s_wdata", 64'(bus.s_wdata), 64'h1234);
        tick();
        clear_masters();
        sample();
        check_idle("rw_end");

        // Request withdrawn during a stall: arbiter returns to idle
        tick();
        bus.m_rd[1]    = 1'b1;
        bus.m_addr[1]  = 32'h300;
        bus.s_wait_req = 1'b1;
        sample();
        tick();
        sample();
        check("pv_c1_grant", 64'(bus.grant_idx), 64'h1);
        check("pv_c1_s_rd", 64'(bus.s_rd), 64'h1);
        tick();
        bus.m_rd[1] = 1'b0;
        sample();
        check("pv_c2_grant", 64'(bus.grant_idx), 64'h1);
        check("pv_c2_s_addr", 64'(bus.s_addr), 64'h300);
        tick();
        bus.s_wait_req = 1'b0;
        sample();
        check_idle("pv_c3");

        // Reset during a stalled write from master 1
        tick();
        bus.m_wr[1]    = 1'b1;
        bus.m_addr[1]  = 32'h500;
        bus.m_wdata[1] = 32'hAA;
        bus.s_wait_req = 1'b1;
        sample();
        tick();
        sample();
        check("mr_pre_s_wr", 64'(bus.s_wr), 64'h1);
        check("mr_pre_grant", 64'(bus.grant_idx), 64'h1);
        #2;
        areset = 1'b0;
        #1;
        check("mr_s_wr", 64'(bus.s_wr), 64'h0);
        check("mr_wait", 64'(bus.m_wait_req), 64'h7);
        check("mr_grant", 64'(bus.grant_idx), 64'h0);
        check("mr_s_addr", 64'(bus.s_addr), 64'h0);

        // All three request continuously after release
        tick();
        clear_masters();
        areset         = 1'b1;
        bus.s_wait_req = 1'b0;
        bus.m_rd       = 3'b111;
        bus.m_addr[0]  = 32'h1000;
        bus.m_addr[1]  = 32'h1100;
        bus.m_addr[2]  = 32'h1200;
        sample();
        check("all_c0_wait", 64'(bus.m_wait_req), 64'h7);
`ifdef QRISC_ARB_ROUND_ROBIN_EN
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
`else
        rr_exp = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif
        for (int i = 0; i < 6; i++) begin
            tick();
            sample();
            check("all_grant", 64'(bus.grant_idx), 64'(rr_exp[i]));
            check("all_wait", 64'(bus.m_wait_req), 64'(3'b111 & ~(3'b001 << rr_exp[i])));
            check("all_s_rd", 64'(bus.s_rd), 64'h1);
        end
        bus.m_rd = '0;
        tick();
        sample();
        check_idle("all_end");

        // Fresh reset so the pointer starts from its reset value
        tick();
        areset = 1'b0;
        sample();
        tick();
        areset = 1'b1;

        // Masters 0 and 2 request continuously: 0, 2, 0, 2
        tick();
        bus.m_rd = 3'b101;
        sample();
        for (int i = 0; i < 4; i++) begin
            tick();
            sample();
            check("p02_grant", 64'(bus.grant_idx), (i % 2 == 0) ? 64'h0 : 64'h2);
            check("p02_wait", 64'(bus.m_wait_req), (i % 2 == 0) ? 64'h6 : 64'h3);
        end
        bus.m_rd = '0;
        tick();
        sample();
        check_idle("p02_end");

        // Only master 2 requests: grant alternates with idle
        tick();
        bus.m_rd = 3'b100;
        sample();
        for (int i = 0; i < 4; i++) begin
            tick();
            sample();
            check("p2_wait", 64'(bus.m_wait_req), (i % 2 == 0) ? 64'h3 : 64'h7);
            check("p2_s_rd", 64'(bus.s_rd), (i % 2 == 0) ? 64'h1 : 64'h0);
        end
        bus.m_rd = '0;
        tick();
        sample();
        check_idle("p2_end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
